// File: rtl/modem_tdd_sched.sv
// Half-duplex slot scheduler: sequences TX/RX chain resets, TX gating and the
// loopback switch through alternating RX and TX slots with warm-up and guard gaps.
//
// state    | meaning
// IDLE     | disabled, both chains held in reset
// RX_WARM  | RX chain released, settling before its slot opens
// RX_SLOT  | receiving; may be extended while a frame is in progress
// GUARD    | both chains in reset between direction changes
// TX_WARM  | TX chain released, settling before its slot opens
// TX_SLOT  | transmitting, TX input accepted
// LOOP     | loopback: both chains live, TX samples routed into RX
module modem_tdd_sched #(
    parameter int CNT_W    = 16,
    parameter int WARM_CYC = 8
) (
    input  logic             clk_l,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] rx_slot_len,
    input  logic [CNT_W-1:0] tx_slot_len,
    input  logic [CNT_W-1:0] guard_len,
    input  logic [CNT_W-1:0] rx_ext_max,
    input  logic             tx_req,
    input  logic             rx_busy,
    output logic             tx_rst_out,
    output logic             rx_rst_out,
    output logic             switch_on,
    output logic             tx_gate,
    output logic             rx_tx_en,
    output logic [2:0]       state_out,
    output logic [15:0]      tx_slot_cnt,
    output logic             rx_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_WARM = 3'd1,
        ST_RX_SLOT = 3'd2,
        ST_GUARD   = 3'd3,
        ST_TX_WARM = 3'd4,
        ST_TX_SLOT = 3'd5,
        ST_LOOP    = 3'd6
    } state_t;

    localparam logic [1:0]       MODE_TDD  = 2'd0;
    localparam logic [1:0]       MODE_TX   = 2'd1;
    localparam logic [1:0]       MODE_RX   = 2'd2;
    localparam logic [1:0]       MODE_LOOP = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARM_CYC - 1);

    // A programmed length of zero behaves as a one-cycle interval.
    function automatic logic [CNT_W-1:0] last_of(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_ONE;
    endfunction

    // Bit order: tx_rst, rx_rst, tx_gate, rx_tx_en, switch_on
    function automatic logic [4:0] ctrl_of(input state_t s);
        logic [4:0] c;
        case (s)
            ST_RX_WARM: c = 5'b10000;
            ST_RX_SLOT: c = 5'b10000;
            ST_GUARD:   c = 5'b11000;
            ST_TX_WARM: c = 5'b01010;
            ST_TX_SLOT: c = 5'b01110;
            ST_LOOP:    c = 5'b00111;
            default:    c = 5'b11000;
        endcase
        return c;
    endfunction

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] ext;
    logic [CNT_W-1:0] ext_nx;
    logic             dir_tx;
    logic             dir_tx_nx;
    logic [1:0]       mode_q;
    logic [1:0]       mode_q_nx;
    logic             slot_done;
    logic             ovr_nx;
    logic [4:0]       ctrl_nx;

    logic warm_end;
    logic rx_end;
    logic tx_end;
    logic guard_end;

    assign warm_end  = (cnt == WARM_LAST);
    assign rx_end    = (cnt == last_of(rx_slot_len));
    assign tx_end    = (cnt == last_of(tx_slot_len));
    assign guard_end = (cnt == last_of(guard_len));

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + CNT_ONE;
        ext_nx    = ext;
        dir_tx_nx = dir_tx;
        mode_q_nx = mode_q;
        slot_done = 1'b0;
        ovr_nx    = 1'b0;

        if (!en) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
            ext_nx   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_nx    = '0;
                    ext_nx    = '0;
                    mode_q_nx = mode;
                    if (mode == MODE_LOOP) begin
                        state_nx = ST_LOOP;
                    end else if (mode == MODE_TX) begin
                        state_nx = ST_TX_WARM;
                    end else begin
                        state_nx = ST_RX_WARM;
                    end
                end
                ST_RX_WARM: begin
                    if (warm_end) begin
                        state_nx = ST_RX_SLOT;
                        cnt_nx   = '0;
                    end
                end
                ST_TX_WARM: begin
                    if (warm_end) begin
                        state_nx = ST_TX_SLOT;
                        cnt_nx   = '0;
                    end
                end
                ST_RX_SLOT: begin
                    if (rx_end) begin
                        if (mode_q == MODE_RX) begin
                            cnt_nx = '0;
                        end else if (rx_busy && (ext < rx_ext_max)) begin
                            // Frame still arriving: freeze the slot end and spend extension budget.
                            cnt_nx = cnt;
                            ext_nx = ext + CNT_ONE;
                        end else begin
                            ovr_nx = rx_busy;
                            cnt_nx = '0;
                            ext_nx = '0;
                            if (!((mode_q == MODE_TDD) && !tx_req)) begin
                                state_nx  = ST_GUARD;
                                dir_tx_nx = 1'b1;
                            end
                        end
                    end
                end
                ST_GUARD: begin
                    if (guard_end) begin
                        state_nx = dir_tx ? ST_TX_WARM : ST_RX_WARM;
                        cnt_nx   = '0;
                    end
                end
                ST_TX_SLOT: begin
                    if (tx_end) begin
                        slot_done = 1'b1;
                        cnt_nx    = '0;
                        if (mode_q != MODE_TX) begin
                            state_nx  = ST_GUARD;
                            dir_tx_nx = 1'b0;
                        end
                    end
                end
                ST_LOOP: begin
                    cnt_nx = '0;
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                    ext_nx   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state decode so they move with the state.
    always_comb begin
        ctrl_nx = ctrl_of(state_nx);
    end

    always_ff @(posedge clk_l) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ext         <= '0;
            dir_tx      <= 1'b0;
            mode_q      <= MODE_TDD;
            tx_slot_cnt <= '0;
            rx_overrun  <= 1'b0;
            tx_rst_out  <= 1'b1;
            rx_rst_out  <= 1'b1;
            tx_gate     <= 1'b0;
            rx_tx_en    <= 1'b0;
            switch_on   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            ext        <= ext_nx;
            dir_tx     <= dir_tx_nx;
            mode_q     <= mode_q_nx;
            rx_overrun <= ovr_nx;
            if (slot_done) begin
                tx_slot_cnt <= tx_slot_cnt + 16'd1;
            end
            tx_rst_out <= ctrl_nx[4];
            rx_rst_out <= ctrl_nx[3];
            tx_gate    <= ctrl_nx[2];
            rx_tx_en   <= ctrl_nx[1];
            switch_on  <= ctrl_nx[0];
        end
    end

    assign state_out = state;

endmodule

// File: doc/modem_tdd_sched.md
Name: modem_tdd_sched

Overview:
- Half-duplex (TDD) slot scheduler for the modem transmit and receive chains.
- Sequences the TX-chain reset, RX-chain reset, TX input gating and the TX-to-RX loopback switch through alternating RX and TX slots, with warm-up and guard intervals.
- Sits between the AXI-Lite control register block and the TX/RX chains.
- Replaces the static register-driven tx/rx reset and loopback-switch bits.

Parameters:
CNT_W, 16, width of the slot/guard length inputs and the internal cycle counter
WARM_CYC, 8, cycles a chain is held out of reset before its slot opens (>=1)

Ports:
clk_l  in  1  system clock; all logic in this single domain
rst  in  1  synchronous, active-high reset
en  in  1  scheduler enable
mode  in  2  0=TDD, 1=TX only, 2=RX only, 3=loopback
rx_slot_len  in  CNT_W  RX slot length in cycles
tx_slot_len  in  CNT_W  TX slot length in cycles
guard_len  in  CNT_W  guard interval in cycles
rx_ext_max  in  CNT_W  maximum RX slot extension in cycles
tx_req  in  1  TX data pending (upstream tvalid)
rx_busy  in  1  RX frame in progress (preamble detected)
tx_rst_out  out  1  TX-chain reset, active-high
rx_rst_out  out  1  RX-chain reset, active-high
switch_on  out  1  loopback select (TX samples into RX)
tx_gate  out  1  permits TX input acceptance (ANDed into tready)
rx_tx_en  out  1  1 while transmitting (LED)
state_out  out  3  current state code
tx_slot_cnt  out  16  completed TX slots, wraps at 0xFFFF->0
rx_overrun  out  1  one-cycle pulse when RX extension is exhausted while rx_busy=1

Behaviour:
- Reset:
  - state=IDLE, cnt=0, ext=0, tx_slot_cnt=0, rx_overrun=0.
  - Outputs take the IDLE values listed below.
- Output timing:
  - All outputs are registered.
  - Control outputs are a pure decode of the state register, so they change on the same edge as the state.
- Lengths:
  - A length of 0 on rx_slot_len, tx_slot_len or guard_len is treated as 1.
  - Slot end occurs at cnt == len-1; cnt resets to 0 on every state entry.
- mode is latched into mode_q on the IDLE exit edge; changes while running are ignored until en falls.
- States (code: tx_rst, rx_rst, tx_gate, rx_tx_en, switch_on):
  - IDLE(0): 1,1,0,0,0
  - RX_WARM(1): 1,0,0,0,0
  - RX_SLOT(2): 1,0,0,0,0
  - GUARD(3): 1,1,0,0,0
  - TX_WARM(4): 0,1,0,1,0
  - TX_SLOT(5): 0,1,1,1,0
  - LOOP(6): 0,0,1,1,1
- Transitions:
  - IDLE, en=1: mode 0 or 2 -> RX_WARM; mode 1 -> TX_WARM; mode 3 -> LOOP.
  - RX_WARM/TX_WARM: after WARM_CYC cycles -> RX_SLOT/TX_SLOT respectively.
  - RX_SLOT end, checked in this priority order:
    - mode_q=2: wrap, cnt=0, stay in RX_SLOT.
    - rx_busy=1 and ext<rx_ext_max: stay and hold cnt; ext++ each cycle.
    - rx_busy=1 and ext==rx_ext_max: pulse rx_overrun, then apply the next rule.
    - mode_q=0 and tx_req=0: restart RX_SLOT (cnt=0, ext=0), no guard.
    - otherwise -> GUARD with dir=TX; ext=0.
  - GUARD: after guard_len cycles -> TX_WARM if dir=TX, RX_WARM if dir=RX.
  - TX_SLOT end: tx_slot_cnt++.
    - mode_q=1: wrap, stay in TX_SLOT.
    - mode_q=0: -> GUARD with dir=RX.
  - LOOP: holds while en=1.
- en=0 in any state -> IDLE on the next edge, regardless of counters. This forces both resets and clears cnt and ext; tx_slot_cnt is kept.
- rst has priority over all other inputs.

Test Plan:
1. Reset held 3 cycles -> state_out=0, tx_rst_out=1, rx_rst_out=1, tx_gate=0, tx_slot_cnt=0.
2. TDD, WARM_CYC=8, rx_slot_len=20, guard_len=4, tx_slot_len=30, tx_req=1, en rises at cycle 0 -> RX_WARM cycles 1-8, RX_SLOT 9-28, GUARD 29-32, TX_WARM 33-40, TX_SLOT 41-70 with tx_gate=1, GUARD from 71; tx_slot_cnt=1 at 71.
3. Case 2 with tx_req=0 at RX slot end -> RX_SLOT restarts with no GUARD; tx_rst_out stays 1; tx_slot_cnt unchanged.
4. Case 2 with rx_busy=1 through slot end, rx_ext_max=5 -> RX_SLOT lasts 25 cycles; rx_overrun=1 for exactly one cycle at the exhaust edge; then GUARD.
5. mode=3, en=1 -> LOOP with switch_on=1 and both resets 0; set mode=0 while running -> stays in LOOP; en=0 -> IDLE next edge, switch_on=0.
6. mode=1, tx_slot_len=0 -> TX_SLOT wraps every cycle and tx_slot_cnt increments each cycle; run 65536+2 slots -> counter wraps to 0 and reads 2.
